output_mem_ctrl: RTL and testbench
==================================

// Module: output_mem_ctrl
// PURPOSE
// - Address/enable sequencer for the output (accumulator-side) memory at the bottom of the systolic array.
// - Write phase (de-skew): column j of the array emits result row r at a skewed time. The block issues
//   per-column wr_en/wr_addr so that each column bank stores row r at address r.
// - Read phase (drain): all column banks are read in parallel, one row per cycle, toward the output/host path.
// PARAMETERS
// - SYS_ROW     16    systolic array rows; informational only, no logic depends on it
// - SYS_COL     16    systolic array columns = number of output memory banks
// - DATA_WIDTH  16    width of the num_row port
// - ACCUM_SIZE  4096  total output memory entries; ACCUM_ROW = ACCUM_SIZE/SYS_COL rows per bank
// - ADDR_WIDTH  8     bank address width; must equal $clog2(ACCUM_ROW)
// PORTS
// - clk         in   1                   clock, all state updates on posedge
// - rstn        in   1                   reset: synchronous, active-low
// - wr_en_in    in   1                   1-cycle start pulse for the write phase (result capture)
// - rd_en_in    in   1                   1-cycle start pulse for the read phase (drain)
// - num_row     in   DATA_WIDTH          rows to capture; sampled on the accepted wr_en_in
// - wr_en       out  SYS_COL             per-bank write enable, skewed
// - wr_addr     out  ADDR_WIDTH x SYS_COL per-bank write address (unpacked [0:SYS_COL-1])
// - rd_en       out  SYS_COL             per-bank read enable, all bits equal
// - rd_addr     out  ADDR_WIDTH          shared read address for all banks
// - wr_done     out  1                   1-cycle pulse: capture complete
// - rd_done     out  1                   1-cycle pulse: drain complete
// - busy        out  1                   high whenever the FSM is not in IDLE
// BEHAVIOUR
// - Reset (rstn=0 at posedge): FSM=IDLE; all outputs 0; stored row count N=0. Reset mid-phase aborts
//   immediately. No done pulse is generated for an aborted phase.
// - FSM states: IDLE, WRITE, READ.
//   - IDLE -> WRITE on wr_en_in. IDLE -> READ on rd_en_in.
//   - WRITE -> IDLE one cycle after wr_done. READ -> IDLE one cycle after rd_done.
// - Both starts in the same IDLE cycle: write wins; the read request is dropped.
// - Start pulses that arrive while busy=1 are ignored (no queuing).
// - Row count: on the accepted wr_en_in, N = min(num_row, ACCUM_ROW) is latched. N is retained for later reads.
// - Write timing: wr_en_in sampled high at edge T.
//   - Column j row r result is valid at the array output during the cycle after edge T+1+j+r.
//   - wr_en[j] is registered high for the N consecutive cycles starting after edge T+1+j. Bit j is bit j-1
//     delayed by exactly one cycle.
//   - wr_addr[j] = 0 for the first enabled cycle and increments by 1 after each cycle with wr_en[j]=1, so it
//     runs 0..N-1. It returns to 0 when the phase ends.
//   - wr_done pulses in the cycle after the last wr_en[SYS_COL-1] cycle. Write phase length = N+SYS_COL cycles.
// - Read timing: rd_en_in sampled high at edge T.
//   - rd_en = all ones for N cycles starting after edge T+1. rd_addr runs 0..N-1 during those cycles.
//   - rd_done pulses in the cycle after the last read. rd_addr returns to 0.
// - N=0 (num_row=0, or a read before any write): no enables are asserted. The done pulse is issued in the
//   cycle after edge T+1.
// - num_row > ACCUM_ROW: clamped to ACCUM_ROW. Addresses never wrap past ACCUM_ROW-1.
// - Counters are internal COUNT_WIDTH = ADDR_WIDTH+1 bits so that N=ACCUM_ROW is representable.
//   Addresses are the low ADDR_WIDTH bits.
// CONFIGURATION
// - OUT_MEM_DBUF_EN undefined: single buffer. Behaviour exactly as above.
// - OUT_MEM_DBUF_EN defined: ping-pong banks. Adds outputs wr_bank (1 bit) and rd_bank (1 bit); memory
//   address = {bank, addr}.
//   - WRITE and READ run as independent sub-FSMs with separate busy_wr and busy_rd; busy = busy_wr | busy_rd.
//   - wr_bank toggles on each wr_done. rd_bank and the read N are latched at rd_en_in from the last
//     completed write.
//   - A read may overlap a write into the other bank; simultaneous starts are both accepted.
//   - Reset clears both bank bits to 0.
// TESTING
// - rstn=0 for 2 cycles -> all outputs 0, busy=0. Pulse rd_en_in -> rd_done one cycle after edge T+1,
//   rd_en never asserted.
// - num_row=4, SYS_COL=16, wr_en_in at T -> wr_en[0] high after edges T+1..T+4 with addr 0..3;
//   wr_en[15] high after edges T+16..T+19; wr_done pulse once after edge T+20.
// - Then rd_en_in -> rd_en=16'hFFFF for 4 cycles with rd_addr 0,1,2,3; rd_done once; busy low afterwards.
// - num_row=1000 (>256) -> exactly 256 writes per bank, wr_addr 0..255, no wrap; a following read drains
//   256 rows.
// - wr_en_in and rd_en_in in the same cycle -> only the write runs. rd_en_in mid-write -> ignored.
//   rstn low mid-write -> outputs 0 next cycle, no wr_done.
// - With OUT_MEM_DBUF_EN: write N=8 (bank0), start write N=8 into bank1 and a read in the same cycle ->
//   rd_bank=0 read of 8 rows overlaps the write with wr_bank=1.

Source files
------------

// File: rtl/output_mem_ctrl_if.sv
// output_mem_ctrl_if: start/size inputs and per-bank enable/address outputs of the output memory sequencer; OUT_MEM_DBUF_EN adds the ping-pong bank bits
interface output_mem_ctrl_if #(
  parameter int SYS_COL    = 16,
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 8
);
  logic                  wr_en_in;
  logic                  rd_en_in;
  logic [DATA_WIDTH-1:0] num_row;
  logic [SYS_COL-1:0]    wr_en;
  logic [ADDR_WIDTH-1:0] wr_addr [0:SYS_COL-1];
  logic [SYS_COL-1:0]    rd_en;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic                  wr_done;
  logic                  rd_done;
  logic                  busy;
`ifdef OUT_MEM_DBUF_EN
  logic                  wr_bank;
  logic                  rd_bank;
  modport master (
    output wr_en_in, rd_en_in, num_row,
    input  wr_en, wr_addr, rd_en, rd_addr, wr_done, rd_done, busy, wr_bank, rd_bank
  );
  modport slave (
    input  wr_en_in, rd_en_in, num_row,
    output wr_en, wr_addr, rd_en, rd_addr, wr_done, rd_done, busy, wr_bank, rd_bank
  );
`else
  modport master (
    output wr_en_in, rd_en_in, num_row,
    input  wr_en, wr_addr, rd_en, rd_addr, wr_done, rd_done, busy
  );
  modport slave (
    input  wr_en_in, rd_en_in, num_row,
    output wr_en, wr_addr, rd_en, rd_addr, wr_done, rd_done, busy
  );
`endif
endinterface

// File: rtl/output_mem_ctrl.sv
// output_mem_ctrl: de-skewed write / parallel drain sequencer for the systolic array output banks; OUT_MEM_DBUF_EN selects ping-pong banks with overlapping read and write
module output_mem_ctrl #(
  parameter int SYS_ROW    = 16,
  parameter int SYS_COL    = 16,
  parameter int DATA_WIDTH = 16,
  parameter int ACCUM_SIZE = 4096,
  parameter int ADDR_WIDTH = 8
) (
  input logic              clk,
  input logic              rstn,
  output_mem_ctrl_if.slave bus
);
  localparam int ACCUM_ROW = ACCUM_SIZE / SYS_COL;
  localparam int CW = ADDR_WIDTH + 1;
  localparam int PW = $clog2(ACCUM_ROW + SYS_COL + 1);
  typedef enum logic [1:0] {IDLE, WRITE, READ} state_t;
  logic [CW-1:0] wn, rn, clamp_n, rcnt;
  logic [PW-1:0] wcnt;
  logic wr_go, rd_go, wr_act, rd_act, w_on, r_on, w_last;
  if (ADDR_WIDTH != $clog2(ACCUM_SIZE / SYS_COL) || SYS_ROW < 1) begin : g_cfg_check
    $error("output_mem_ctrl: ADDR_WIDTH must equal clog2(ACCUM_SIZE/SYS_COL)");
  end
  assign clamp_n = (bus.num_row > DATA_WIDTH'(ACCUM_ROW)) ? CW'(ACCUM_ROW) : CW'(bus.num_row);
  assign w_on = wcnt < PW'(wn);
  assign r_on = rcnt < rn;
  assign w_last = (wn == '0) ? (wcnt == '0) : (wcnt == PW'(wn) + PW'(SYS_COL - 1));
`ifdef OUT_MEM_DBUF_EN
  state_t wr_st, rd_st;
  logic [CW-1:0] last_n;
  logic last_bank;
  assign wr_act = wr_st == WRITE;
  assign rd_act = rd_st == READ;
  assign wr_go = wr_st == IDLE && bus.wr_en_in;
  assign rd_go = rd_st == IDLE && bus.rd_en_in;
  assign bus.busy = wr_act | rd_act;
  // independent write and read sub-FSMs, each returning to IDLE after its done pulse
  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_st <= IDLE;
      rd_st <= IDLE;
    end else begin
      wr_st <= wr_go ? WRITE : bus.wr_done ? IDLE : wr_st;
      rd_st <= rd_go ? READ : bus.rd_done ? IDLE : rd_st;
    end
  end
  // bank flip on write completion; a read drains the bank and size of the last completed write
  always_ff @(posedge clk) begin
    if (!rstn) begin
      bus.wr_bank <= 1'b0;
      bus.rd_bank <= 1'b0;
      last_bank   <= 1'b0;
      last_n      <= '0;
      rn          <= '0;
    end else begin
      if (bus.wr_done) begin
        bus.wr_bank <= ~bus.wr_bank;
        last_bank   <= bus.wr_bank;
        last_n      <= wn;
      end
      if (rd_go) begin
        bus.rd_bank <= last_bank;
        rn          <= last_n;
      end
    end
  end
`else
  state_t state;
  assign wr_act = state == WRITE;
  assign rd_act = state == READ;
  assign wr_go = state == IDLE && bus.wr_en_in;
  assign rd_go = state == IDLE && bus.rd_en_in && !bus.wr_en_in;
  assign bus.busy = state != IDLE;
  assign rn = wn;
  // single phase FSM: write has priority, back to IDLE the cycle after a done pulse
  always_ff @(posedge clk) begin
    if (!rstn) state <= IDLE;
    else state <= wr_go ? WRITE : rd_go ? READ : (bus.wr_done || bus.rd_done) ? IDLE : state;
  end
`endif
  // latch the clamped row count of an accepted write
  always_ff @(posedge clk) begin
    if (!rstn) wn <= '0;
    else if (wr_go) wn <= clamp_n;
  end
  // column 0 follows the phase counter; every other column is its left neighbour one cycle later
  always_ff @(posedge clk) begin
    if (!rstn || !wr_act) begin
      wcnt        <= '0;
      bus.wr_en   <= '0;
      bus.wr_done <= 1'b0;
      for (int j = 0; j < SYS_COL; j++) bus.wr_addr[j] <= '0;
    end else begin
      wcnt           <= wcnt + 1'b1;
      bus.wr_en[0]   <= w_on;
      bus.wr_addr[0] <= w_on ? wcnt[ADDR_WIDTH-1:0] : '0;
      for (int j = 1; j < SYS_COL; j++) begin
        bus.wr_en[j]   <= bus.wr_en[j-1];
        bus.wr_addr[j] <= bus.wr_addr[j-1];
      end
      bus.wr_done <= w_last;
    end
  end
  // drain all banks in lockstep, one row per cycle, then pulse done
  always_ff @(posedge clk) begin
    if (!rstn || !rd_act) begin
      rcnt        <= '0;
      bus.rd_en   <= '0;
      bus.rd_addr <= '0;
      bus.rd_done <= 1'b0;
    end else begin
      rcnt        <= rcnt + 1'b1;
      bus.rd_en   <= {SYS_COL{r_on}};
      bus.rd_addr <= r_on ? rcnt[ADDR_WIDTH-1:0] : '0;
      bus.rd_done <= rcnt == rn;
    end
  end
endmodule

// File: tb/tb_output_mem_ctrl.sv
// tb_output_mem_ctrl: scoreboard bench; stimulus queues expected per-column writes, reads and done pulses, a negedge monitor pops and compares
module tb_output_mem_ctrl;
  localparam int SYS_COL = 16;
  localparam int DW = 16;
  localparam int AW = 8;
  localparam int AROW = 256;
  typedef struct {int c; int a;} ev_t;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  ev_t wq[SYS_COL][$];
  ev_t rq[$];
  int wdq[$], rdq[$];
  int cyc = 0, n_chk = 0, n_pass = 0;
  int free_at = 0, busy_from = 0, model_n = 0;
  bit mon_on = 1'b0;

  output_mem_ctrl_if #(.SYS_COL(SYS_COL), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();
  output_mem_ctrl #(.SYS_ROW(16), .SYS_COL(SYS_COL), .DATA_WIDTH(DW), .ACCUM_SIZE(4096), .ADDR_WIDTH(AW))
    dut (.clk(clk), .rstn(rstn), .bus(bus));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_val(string name, int got, int want);
    n_chk++;
    if (got == want) n_pass++;
    else $display("FAIL %s: got %0d, want %0d (after edge %0d)", name, got, want, cyc);
  endtask

  task automatic check_ev(string name, int gc, int ga, int wc, int wa);
    n_chk++;
    if (gc == wc && ga == wa) n_pass++;
    else $display("FAIL %s: got edge %0d addr %0d, want edge %0d addr %0d", name, gc, ga, wc, wa);
  endtask

  // monitor: every asserted output must match the head of its expected queue
  always @(negedge clk) begin
    ev_t e;
    if (mon_on) begin
      for (int j = 0; j < SYS_COL; j++) begin
        if (bus.wr_en[j]) begin
          if (wq[j].size() == 0) check_ev($sformatf("wr_en[%0d] unexpected", j), cyc, int'(bus.wr_addr[j]), -1, -1);
          else begin
            e = wq[j].pop_front();
            check_ev($sformatf("wr col %0d", j), cyc, int'(bus.wr_addr[j]), e.c, e.a);
          end
        end
      end
      if (bus.rd_en != '0) begin
        check_val("rd_en all banks", int'(bus.rd_en), 'hFFFF);
        if (rq.size() == 0) check_ev("rd_en unexpected", cyc, int'(bus.rd_addr), -1, -1);
        else begin
          e = rq.pop_front();
          check_ev("read", cyc, int'(bus.rd_addr), e.c, e.a);
        end
      end
      if (bus.wr_done) check_val("wr_done edge", cyc, wdq.size() ? wdq.pop_front() : -1);
      if (bus.rd_done) check_val("rd_done edge", cyc, rdq.size() ? rdq.pop_front() : -1);
      check_val("busy", int'(bus.busy), int'(cyc >= busy_from && cyc + 1 < free_at));
    end
  end

  task automatic start(bit w, bit r, int nr);
    int e, n, d;
    @(posedge clk); #1;
    bus.wr_en_in = w;
    bus.rd_en_in = r;
    bus.num_row = DW'(nr);
    e = cyc + 1;
    if (e >= free_at && (w || r)) begin
      if (w) begin
        model_n = nr > AROW ? AROW : nr;
        n = model_n;
        for (int j = 0; j < SYS_COL; j++)
          for (int k = 0; k < n; k++) wq[j].push_back(ev_t'{c: e + 1 + j + k, a: k});
        d = n == 0 ? e + 1 : e + n + SYS_COL;
        wdq.push_back(d);
      end else begin
        n = model_n;
        for (int k = 0; k < n; k++) rq.push_back(ev_t'{c: e + 1 + k, a: k});
        d = e + n + 1;
        rdq.push_back(d);
      end
      busy_from = e;
      free_at = d + 2;
    end
    @(posedge clk); #1;
    bus.wr_en_in = 1'b0;
    bus.rd_en_in = 1'b0;
  endtask

  task automatic idle(int k);
    repeat (k) @(posedge clk);
  endtask

  task automatic wait_idle();
    while (cyc + 1 < free_at) @(posedge clk);
  endtask

  task automatic do_reset(int k);
    @(posedge clk); #1;
    rstn = 1'b0;
    @(posedge clk); #1;
    for (int j = 0; j < SYS_COL; j++) wq[j].delete();
    rq.delete();
    wdq.delete();
    rdq.delete();
    free_at = 0;
    busy_from = 0;
    model_n = 0;
    repeat (k - 1) @(posedge clk);
    #1 rstn = 1'b1;
  endtask

  task automatic check_quiet();
    int acc = 0;
    for (int j = 0; j < SYS_COL; j++) acc |= int'(bus.wr_addr[j]);
    check_val("quiet wr_en", int'(bus.wr_en), 0);
    check_val("quiet wr_addr", acc, 0);
    check_val("quiet rd_en", int'(bus.rd_en), 0);
    check_val("quiet rd_addr", int'(bus.rd_addr), 0);
    check_val("quiet wr_done", int'(bus.wr_done), 0);
    check_val("quiet rd_done", int'(bus.rd_done), 0);
    check_val("quiet busy", int'(bus.busy), 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed so far", n_pass, n_chk);
    $fatal(1, "watchdog");
  end

  initial begin
    int op, nr;
    bus.wr_en_in = 1'b0;
    bus.rd_en_in = 1'b0;
    bus.num_row = '0;
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
    check_quiet();
    mon_on = 1'b1;
    start(0, 1, 0);
    wait_idle();
    start(1, 0, 4);
    wait_idle();
    start(0, 1, 0);
    wait_idle();
    start(1, 0, 1000);
    wait_idle();
    start(0, 1, 0);
    wait_idle();
    start(1, 1, 3);
    wait_idle();
    start(1, 0, 20);
    idle(5);
    start(0, 1, 0);
    start(1, 0, 7);
    wait_idle();
    start(0, 1, 0);
    wait_idle();
    start(1, 0, 30);
    idle(10);
    do_reset(2);
    check_quiet();
    start(0, 1, 0);
    wait_idle();
    start(1, 0, 0);
    wait_idle();
    start(0, 1, 0);
    wait_idle();
    start(1, 0, 256);
    wait_idle();
    start(0, 1, 0);
    wait_idle();
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 1) == 1) wait_idle();
      idle($urandom_range(0, 4));
      op = $urandom_range(0, 9);
      case ($urandom_range(0, 3))
        0: nr = $urandom_range(0, 3);
        1: nr = $urandom_range(0, 40);
        2: nr = $urandom_range(250, 260);
        default: nr = $urandom_range(0, 65535);
      endcase
      if (op == 0) do_reset($urandom_range(1, 3));
      else start(op <= 4 || op == 9, op >= 5, nr);
    end
    wait_idle();
    idle(3);
    for (int j = 0; j < SYS_COL; j++) check_val($sformatf("missing writes col %0d", j), wq[j].size(), 0);
    check_val("missing reads", rq.size(), 0);
    check_val("missing wr_done", wdq.size(), 0);
    check_val("missing rd_done", rdq.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
